// File: rtl/byte_packer_if.sv
// -----------------------------------------------------------------------------
// byte_packer_if
// Byte-stream / word-FIFO signal bundle for byte_packer.
//   byte_in[7:0]    upstream data byte
//   byte_valid      byte_in holds a valid byte
//   byte_ready      packer can accept a byte this cycle
//   flush           emit any partial word, padded
//   full            downstream FIFO cannot accept a write
//   wr_en           one-cycle FIFO write strobe
//   data_out[31:0]  packed word, valid while wr_en=1
//   fill[1:0]       bytes held in the partial word
//   parity_in       even parity over byte_in (BYTE_PACKER_PARITY_EN only)
//   parity_err      sticky parity error flag (BYTE_PACKER_PARITY_EN only)
// Modports: master = upstream/FIFO side, slave = packer.
// Optional feature macro: BYTE_PACKER_PARITY_EN.
// -----------------------------------------------------------------------------
interface byte_packer_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        flush;
   logic        full;
   logic        wr_en;
   logic [31:0] data_out;
   logic [1:0]  fill;
`ifdef BYTE_PACKER_PARITY_EN
   logic        parity_in;
   logic        parity_err;

   modport master (
      output byte_in, byte_valid, flush, full, parity_in,
      input  byte_ready, wr_en, data_out, fill, parity_err
   );

   modport slave (
      input  byte_in, byte_valid, flush, full, parity_in,
      output byte_ready, wr_en, data_out, fill, parity_err
   );
`else
   modport master (
      output byte_in, byte_valid, flush, full,
      input  byte_ready, wr_en, data_out, fill
   );

   modport slave (
      input  byte_in, byte_valid, flush, full,
      output byte_ready, wr_en, data_out, fill
   );
`endif
endinterface

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Packs a stream of 8-bit bytes (little-endian) into 32-bit words and writes
// each completed word to a downstream FIFO with a single-cycle wr_en pulse.
// A partial word can be flushed out with unused lanes set to PAD_BYTE.
// While the FIFO is full a completed word is held (STALL) and byte_ready drops.
//
// Parameters:
//   PAD_BYTE  fill value for unused byte lanes on flush
// Ports:
//   clk   rising-edge system clock
//   rst   asynchronous active-high reset
//   bus   byte_packer_if.slave (byte_in/byte_valid/byte_ready, flush, full,
//         wr_en/data_out, fill, and parity_in/parity_err when enabled)
// Optional feature macro: BYTE_PACKER_PARITY_EN
//   adds even-parity checking of byte_in; bad bytes are handshaken but dropped
//   and set the sticky parity_err flag.
// -----------------------------------------------------------------------------
module byte_packer #(
   parameter logic [7:0] PAD_BYTE = 8'h00
) (
   input  logic          clk,
   input  logic          rst,
   byte_packer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic [1:0]  cnt_q;
   logic [31:0] word_q;
   logic [31:0] data_q;
   logic        wr_q;

   logic        byte_ready;
   logic        accept;
   logic        pack;
   logic        par_ok;
   logic [2:0]  cnt_pack;
   logic [31:0] word_pack;
   logic [31:0] word_cmp;
   logic        complete;
   logic        can_write;

`ifdef BYTE_PACKER_PARITY_EN
   logic        parity_err_q;

   assign par_ok = (bus.parity_in == ^bus.byte_in);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err_q <= 1'b0;
      end else if (accept && !par_ok) begin
         parity_err_q <= 1'b1;
      end
   end

   assign bus.parity_err = parity_err_q;
`else
   assign par_ok = 1'b1;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath next values
   always_comb begin
      accept    = bus.byte_valid && byte_ready;
      pack      = accept && par_ok;
      cnt_pack  = {1'b0, cnt_q} + {2'b00, pack};

      // The accepted byte is packed first; a same-edge flush then pads the rest.
      word_pack = word_q;
      if (pack) begin
         word_pack[{cnt_q, 3'b000} +: 8] = bus.byte_in;
      end
      word_cmp = word_pack;
      for (int unsigned i = 0; i < 4; i++) begin
         if (i >= 32'(cnt_pack)) begin
            word_cmp[i*8 +: 8] = PAD_BYTE;
         end
      end

      complete  = (state_q != STALL) &&
                  ((cnt_pack == 3'd4) || (bus.flush && (cnt_pack != 3'd0)));

      // A write in the cycle right after another write is deferred through
      // STALL so wr_en can never be high on two consecutive cycles (reachable
      // when a single byte is flushed right behind an emitted word).
      can_write = !bus.full && !wr_q;

      state_d   = state_q;
      case (state_q)
         STALL: begin
            if (can_write) begin
               state_d = IDLE;
            end
         end
         default: begin
            if (complete) begin
               state_d = can_write ? IDLE : STALL;
            end else if (cnt_pack != 3'd0) begin
               state_d = FILL;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      byte_ready = (state_q != STALL) && !rst;
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         word_q <= '0;
         data_q <= '0;
         wr_q   <= 1'b0;
      end else begin
         wr_q <= 1'b0;
         if (state_q == STALL) begin
            if (can_write) begin
               wr_q   <= 1'b1;
               data_q <= word_q;
            end
         end else if (complete) begin
            cnt_q  <= '0;
            word_q <= word_cmp;
            if (can_write) begin
               wr_q   <= 1'b1;
               data_q <= word_cmp;
            end
         end else begin
            cnt_q  <= cnt_pack[1:0];
            word_q <= word_pack;
         end
      end
   end

   assign bus.byte_ready = byte_ready;
   assign bus.wr_en      = wr_q;
   assign bus.data_out   = data_q;
   assign bus.fill       = cnt_q;

endmodule

// File: tb/tb_byte_packer.sv
// -----------------------------------------------------------------------------
// tb_byte_packer
// Self-checking bench for byte_packer. Expected words are queued as stimulus
// is driven and compared when the packer writes. Define BYTE_PACKER_PARITY_EN
// to also exercise the parity feature.
// -----------------------------------------------------------------------------
module tb_byte_packer;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   byte_packer_if bus ();

   byte_packer #(.PAD_BYTE(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [31:0] exp_q[$];
   int unsigned wr_cyc[$];
   int unsigned wr_count = 0;
   int unsigned cyc      = 0;
   logic        prev_wr  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Write monitor / scoreboard
   always @(negedge clk) begin
      cyc++;
      if (bus.wr_en === 1'b1) begin
         wr_count++;
         wr_cyc.push_back(cyc);
         check("wr_en_back_to_back", 32'(prev_wr), 32'd0);
         if (exp_q.size() == 0) begin
            check("sb_empty_at_write", 32'(exp_q.size()), 32'd1);
         end else begin
            check("word", bus.data_out, exp_q.pop_front());
         end
      end
      prev_wr = bus.wr_en;
   end

   // All tasks leave time at posedge+1.
   task automatic send_byte(input logic [7:0] b, input logic fl);
      logic rdy;
      logic acc;
      acc            = 1'b0;
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      bus.flush      = fl;
`ifdef BYTE_PACKER_PARITY_EN
      bus.parity_in  = ^b;
`endif
      for (int i = 0; i < 50; i++) begin
         rdy = bus.byte_ready;
         @(posedge clk);
         if (rdy) begin
            acc = 1'b1;
            break;
         end
      end
      #1;
      bus.byte_valid = 1'b0;
      bus.flush      = 1'b0;
      if (!acc) check("accept_timeout", 32'(acc), 32'd1);
   endtask

`ifdef BYTE_PACKER_PARITY_EN
   task automatic send_bad(input logic [7:0] b);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      bus.parity_in  = ~(^b);
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
   endtask
`endif

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_flush();
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      check("sb_drain", 32'(exp_q.size()), 32'd0);
   endtask

   logic [31:0] cont_words [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

   initial begin
      int unsigned n;
      int unsigned k;

      bus.byte_in    = '0;
      bus.byte_valid = 1'b0;
      bus.flush      = 1'b0;
      bus.full       = 1'b0;
`ifdef BYTE_PACKER_PARITY_EN
      bus.parity_in  = 1'b0;
`endif
      rst = 1'b1;
      #2;
      check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
      check("rst_wr_en",      32'(bus.wr_en),      32'd0);
      check("rst_data_out",   bus.data_out,        32'h0);
      check("rst_fill",       32'(bus.fill),       32'd0);
`ifdef BYTE_PACKER_PARITY_EN
      check("rst_parity_err", 32'(bus.parity_err), 32'd0);
`endif
      #10;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_rst", 32'(bus.byte_ready), 32'd1);

      // Basic word
      exp_q.push_back(32'h44332211);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      check("fill_two", 32'(bus.fill), 32'd2);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      check("basic_wr_en", 32'(bus.wr_en), 32'd1);
      check("basic_fill0", 32'(bus.fill),  32'd0);
      drain();

      // Flush a partial word, then flush in IDLE
      exp_q.push_back(32'h0000BBAA);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      pulse_flush();
      check("flush_fill0", 32'(bus.fill), 32'd0);
      drain();
      n = wr_count;
      pulse_flush();
      idle(3);
      check("idle_flush_nowr", 32'(wr_count - n), 32'd0);

      // Byte + flush on one edge pads; 4th byte + flush is a normal word
      n = wr_count;
      exp_q.push_back(32'h000000CC);
      send_byte(8'hCC, 1'b1);
      exp_q.push_back(32'hD4D3D2D1);
      send_byte(8'hD1, 1'b0);
      send_byte(8'hD2, 1'b0);
      send_byte(8'hD3, 1'b0);
      send_byte(8'hD4, 1'b1);
      drain();
      idle(3);
      check("flush_combo_writes", 32'(wr_count - n), 32'd2);

      // Back-pressure
      bus.full = 1'b1;
      exp_q.push_back(32'h04030201);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b0);
      check("stall_ready", 32'(bus.byte_ready), 32'd0);
      check("stall_wr_en", 32'(bus.wr_en),      32'd0);
      check("stall_fill",  32'(bus.fill),       32'd0);
      n = wr_count;
      pulse_flush();
      idle(4);
      check("stall_nowr", 32'(wr_count - n), 32'd0);
      bus.full = 1'b0;
      idle(1);
      check("unstall_wr_en", 32'(bus.wr_en),      32'd1);
      check("unstall_data",  bus.data_out,        32'h04030201);
      check("unstall_ready", 32'(bus.byte_ready), 32'd1);
      drain();

      // Continuous stream, one word per 4 cycles
      n = wr_count;
      k = wr_cyc.size();
      foreach (cont_words[i]) exp_q.push_back(cont_words[i]);
      for (int unsigned b = 0; b < 16; b++) begin
         send_byte(8'(b), 1'b0);
      end
      drain();
      check("cont_writes", 32'(wr_count - n), 32'd4);
      if (wr_cyc.size() >= k + 4) begin
         for (int unsigned j = 1; j < 4; j++) begin
            check("cont_spacing", 32'(wr_cyc[k+j] - wr_cyc[k+j-1]), 32'd4);
         end
      end

      // Asynchronous reset mid-word
      send_byte(8'hA1, 1'b0);
      send_byte(8'hA2, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      check("arst_fill",   32'(bus.fill),       32'd0);
      check("arst_wr_en",  32'(bus.wr_en),      32'd0);
      check("arst_data",   bus.data_out,        32'h0);
      check("arst_ready",  32'(bus.byte_ready), 32'd0);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back(32'h8D7C6B5A);
      send_byte(8'h5A, 1'b0);
      send_byte(8'h6B, 1'b0);
      send_byte(8'h7C, 1'b0);
      send_byte(8'h8D, 1'b0);
      drain();

`ifdef BYTE_PACKER_PARITY_EN
      check("par_err_clear", 32'(bus.parity_err), 32'd0);
      exp_q.push_back(32'h05040302);
      send_bad(8'h01);
      check("par_bad_fill", 32'(bus.fill),       32'd0);
      check("par_err_set",  32'(bus.parity_err), 32'd1);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b0);
      send_byte(8'h05, 1'b0);
      drain();
      idle(3);
      check("par_err_sticky", 32'(bus.parity_err), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/byte_packer.md
# byte_packer

- Packs a stream of 8-bit bytes into 32-bit words for the downstream 32-deep word FIFO.
- Each completed word is delivered as a single-cycle write pulse with the word.
- Applies back-pressure upstream while the FIFO reports full.
- Supports flushing a partial word, padded with a fixed byte.

## Interface
Parameters:
- PAD_BYTE, 8'h00, fill value for unused byte lanes on flush

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- byte_in  input  8  data byte from upstream
- byte_valid  input  1  byte_in holds a valid byte
- byte_ready  output  1  packer can accept a byte this cycle
- flush  input  1  emit any partial word, padded
- full  input  1  downstream FIFO cannot accept a write
- wr_en  output  1  one-cycle write strobe to the FIFO
- data_out  output  32  packed word; valid while wr_en=1
- fill  output  2  number of bytes currently held in the partial word (0-3)

## Operation
- **Accept rule:** a byte is accepted at a rising edge when byte_valid=1 and byte_ready=1.
- **Byte order:** little-endian. The first accepted byte of a word goes to [7:0], the second to [15:8], the third to [23:16], the fourth to [31:24].

State machine:
- **IDLE:** 0 bytes held.
  - An accepted byte moves to FILL.
- **FILL:** 1-3 bytes held.
  - Each accepted byte advances fill.
  - On the 4th byte, the word is complete.
- **STALL:** a complete word is held and not yet written.
  - byte_ready=0.

Word completion at edge E (4th byte accepted, or flush):
- If full=0 at E: wr_en<=1, data_out<=word, fill<=0, state<=IDLE.
- If full=1 at E: state<=STALL.
- In STALL, at the first edge with full=0: wr_en<=1, data_out<=word, state<=IDLE.

Flush behaviour:
- **flush in FILL:** unfilled lanes are set to PAD_BYTE and the word completes as above.
- **Byte accepted and flush on the same edge:** the byte is packed first, then flush applies.
  - If that byte made 4 bytes, the result is a normal completion (no pad).
- **flush in IDLE:** no-op; no write.
- **flush in STALL:** ignored.

Outputs:
- byte_ready = (state != STALL) and rst=0; it is combinational from the state.
- wr_en is never high for two consecutive cycles.
- data_out holds its last value when wr_en=0.

Reset (asynchronous, takes effect immediately):
- state=IDLE, fill=0, wr_en=0, data_out=32'h0.
- byte_ready=0 while rst=1.
- A partial or stalled word is discarded.

## Timing
- **Latency:** 4th byte accepted at edge E with full=0 -> wr_en=1 and data_out valid for the cycle after E. The FIFO captures the word at edge E+1.
- **Throughput:** one word per 4 cycles with continuous byte_valid and full=0. A byte may be accepted in the same cycle wr_en=1.
- full is sampled only at the completion edge and at STALL edges. The FIFO must not assert full in response to a write it has not yet received.
- fill updates at the accepting edge. It reads 0 in STALL and after emit.

## Configuration
- Macro: BYTE_PACKER_PARITY_EN.
- **Defined:**
  - Adds input parity_in (1 bit, even parity over byte_in).
  - Adds output parity_err (1 bit, sticky, cleared only by rst, reset value 0).
  - A byte whose parity mismatches completes the handshake but is discarded; fill is unchanged.
  - parity_err sets at that edge.
- **Undefined:** neither port exists and every accepted byte is packed.

## Test plan
- Reset, then bytes 11,22,33,44 on consecutive cycles with full=0 -> one wr_en pulse, data_out=32'h44332211, fill returns 0.
- Bytes AA,BB then flush with PAD_BYTE=8'h00 -> data_out=32'h0000BBAA. flush in IDLE -> no wr_en.
- full=1 while bytes 01,02,03,04 are fed -> STALL with byte_ready=0 and no wr_en. Drop full after 5 cycles -> wr_en one cycle later with 32'h04030201, then byte_ready=1.
- Continuous bytes 00..0F with full=0 -> exactly 4 single-cycle wr_en pulses, 4 cycles apart: 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C.
- Assert rst asynchronously mid-word after 2 bytes -> fill=0, wr_en=0, data_out=0 immediately. Next 4 bytes form a fresh word.
- With BYTE_PACKER_PARITY_EN: bytes 01(bad parity),02,03,04,05 -> parity_err=1 sticky, data_out=32'h05040302.
